// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and saturating increment for the serial pattern detector
package seq_det_pkg;
  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;
  localparam int PAT_LEN_MAX = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction
endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating event counter, clear wins over increment
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  localparam logic [31:0] MAX = 32'({CNT_W{1'b1}});
  always_ff @(posedge clk)
    count <= (reset | clr) ? '0 : inc ? CNT_W'(sat_inc(32'(count), MAX)) : count;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with overlap and Mealy/Moore options
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b1011),
  parameter int                 OVERLAP = 1,
  parameter int                 MOORE   = MODE_MEALY,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_bit,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] pattern
);
  localparam int FW = $clog2(PAT_LEN);
  if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $fatal(1, "seq_detector_param: PAT_LEN must be 2..16");
  end
  logic [PAT_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] shifted;
  logic               match_c;
  logic               out_r;
  assign shifted = {hist, in_bit};
  assign match_c = in_valid & ~pat_load & ~reset & (fill == FW'(PAT_LEN-1)) & (shifted == pattern);
  assign out = (MOORE == MODE_MOORE) ? out_r & ~reset : match_c;
  always_ff @(posedge clk) begin
    out_r <= match_c;
    if (reset) begin
      pattern <= PATTERN;
      hist    <= '0;
      fill    <= '0;
    end else if (pat_load) begin
      pattern <= pat_in;
      hist    <= '0;
      fill    <= '0;
    end else if (in_valid) begin
      // non-overlap mode restarts from an empty history once a match completes
      hist <= (match_c && OVERLAP == 0) ? '0 : shifted[PAT_LEN-2:0];
      fill <= (match_c && OVERLAP == 0) ? '0 : FW'(sat_inc(32'(fill), 32'(PAT_LEN-1)));
    end
  end
  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match_c),
    .clr  (cnt_clr),
    .count(match_count)
  );
endmodule
